// File: rtl/fc_class_sequencer_if.sv
// Bus between the class sequencer and its environment: weight-bank writes, run control,
// neuron hand-off and the classification result.
interface fc_class_sequencer_if #(
  parameter int unsigned WEIGHT_W = 64,
  parameter int unsigned RESULT_W = 8,
  parameter int unsigned IDX_W    = 2
);
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [WEIGHT_W-1:0] wr_data;
  logic                start;
  logic [RESULT_W-1:0] neuron_result;
  logic [WEIGHT_W-1:0] weight_out;
  logic                weight_valid;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    class_id;
  logic [RESULT_W-1:0] class_score;

  modport master (
    output wr_en, wr_addr, wr_data, start, neuron_result,
    input  weight_out, weight_valid, busy, done, class_id, class_score
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, neuron_result,
    output weight_out, weight_valid, busy, done, class_id, class_score
  );
endinterface

// File: rtl/fc_class_sequencer.sv
// Sequences the FC neuron over every class weight vector and keeps a signed argmax
// of the returned scores; reports the winning class once per run.
module fc_class_sequencer #(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned WEIGHT_W    = 64,
  parameter int unsigned RESULT_W    = 8,
  parameter int unsigned RESULT_LAT  = 1,
  parameter int unsigned IDX_W       = 2
) (
  input logic                clk,
  input logic                rst_n,
  fc_class_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t              r_state;
  logic [WEIGHT_W-1:0] r_bank [NUM_CLASSES];
  logic [IDX_W-1:0]    r_k;
  logic [WEIGHT_W-1:0] r_weight_out;
  logic                r_weight_valid;
  logic                r_busy;
  logic                r_done;
  logic [IDX_W-1:0]    r_class_id;
  logic [RESULT_W-1:0] r_class_score;
  logic [RESULT_W-1:0] r_best;
  logic [IDX_W-1:0]    r_best_idx;
  logic                r_dvld [RESULT_LAT];
  logic [IDX_W-1:0]    r_didx [RESULT_LAT];

  logic [IDX_W-1:0]    w_rd_idx;
  logic [WEIGHT_W-1:0] w_bank_rd;
  logic                w_cap_vld;
  logic [IDX_W-1:0]    w_cap_idx;
  logic                w_cap_last;
  logic [RESULT_W-1:0] w_best;
  logic [IDX_W-1:0]    w_best_idx;

  // Bank entry for the next issue: class 0 when launching, k+1 while issuing
  always_comb begin
    w_rd_idx  = (r_state == ST_ISSUE) ? r_k + IDX_W'(1) : '0;
    w_bank_rd = '0;
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      if (w_rd_idx == IDX_W'(i)) begin
        w_bank_rd = r_bank[i];
      end
    end
  end

  assign w_cap_vld  = r_dvld[RESULT_LAT-1];
  assign w_cap_idx  = r_didx[RESULT_LAT-1];
  assign w_cap_last = w_cap_vld && (w_cap_idx == LAST_IDX);

  // Running argmax including this cycle's capture; ties keep the earlier (lower) class
  always_comb begin
    w_best     = r_best;
    w_best_idx = r_best_idx;
    if (w_cap_vld) begin
      if ((w_cap_idx == '0) || ($signed(bus.neuron_result) > $signed(r_best))) begin
        w_best     = bus.neuron_result;
        w_best_idx = w_cap_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_k            <= '0;
      r_weight_out   <= '0;
      r_weight_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_class_id     <= '0;
      r_class_score  <= '0;
      r_best         <= '0;
      r_best_idx     <= '0;
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
        r_bank[i] <= '0;
      end
      for (int unsigned i = 0; i < RESULT_LAT; i++) begin
        r_dvld[i] <= 1'b0;
        r_didx[i] <= '0;
      end
    end else begin
      // Bank is writable only between runs; out-of-range addresses match no entry
      if (bus.wr_en && !r_busy) begin
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
          if (bus.wr_addr == IDX_W'(i)) begin
            r_bank[i] <= bus.wr_data;
          end
        end
      end

      r_dvld[0] <= r_weight_valid;
      r_didx[0] <= r_k;
      for (int unsigned i = 1; i < RESULT_LAT; i++) begin
        r_dvld[i] <= r_dvld[i-1];
        r_didx[i] <= r_didx[i-1];
      end

      if (w_cap_vld) begin
        r_best     <= w_best;
        r_best_idx <= w_best_idx;
      end

      r_done <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state        <= ST_ISSUE;
            r_busy         <= 1'b1;
            r_k            <= '0;
            r_weight_out   <= w_bank_rd;
            r_weight_valid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (r_k == LAST_IDX) begin
            r_state        <= ST_DRAIN;
            r_weight_out   <= '0;
            r_weight_valid <= 1'b0;
          end else begin
            r_k          <= r_k + IDX_W'(1);
            r_weight_out <= w_bank_rd;
          end
        end
        ST_DRAIN: begin
          if (w_cap_last) begin
            r_state       <= ST_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_class_id    <= w_best_idx;
            r_class_score <= w_best;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.weight_out   = r_weight_out;
  assign bus.weight_valid = r_weight_valid;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.class_id     = r_class_id;
  assign bus.class_score  = r_class_score;

endmodule
